seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the board 7-segment driver: samples the multiplexed anode/segment lines and recovers the hexadecimal digit shown on each of the 4 positions.
- Used in ALU board-level benches and self-check logic to read back what the display shows, without tapping the ALU result bus.
- Captures a digit only after the pattern has been stable for a programmable number of cycles; flags patterns that are not valid hex glyphs.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before capture (legal range 1..255).
- SYNC_STAGES, 2, input synchroniser depth (legal range 2..3).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- anodos_i  in  4  anode enables, active-low, one-hot-low when a digit is lit
- segmentos_i  in  8  segment lines, active-low; [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp
- digits_o  out  16  recovered nibbles; digit k at [4k+3:4k], digit 0 = anode bit 0
- valid_o  out  4  digit k holds a decoded value
- dp_o  out  4  captured decimal point per digit, active-high (lit = 1)
- err_o  out  4  last stable pattern on digit k was not a hex glyph
- update_o  out  1  one-cycle pulse when any of digits_o/valid_o/dp_o/err_o changes

Behaviour:
- Reset (async assert, sync release): digits_o=0, valid_o=0, dp_o=0, err_o=0, update_o=0, FSM in IDLE, stability counter 0.
- Inputs pass through SYNC_STAGES flops; all logic below uses the synchronised {anodos, segmentos} sample (12 bits).
- FSM states:
  - IDLE: anodos not exactly one-hot-low. Go to TRACK when it becomes one-hot-low; counter=1.
  - TRACK: sample equal to previous sample -> counter++. Sample differs but is still one-hot-low -> counter=1, stay. Not one-hot-low -> IDLE. When counter reaches STABLE_CYCLES -> CAPTURE.
  - CAPTURE: single cycle. Writes the decode to the selected digit slot, then goes to HOLD.
  - HOLD: sample unchanged -> stay, no re-capture. Changed and one-hot-low -> TRACK with counter=1. Otherwise -> IDLE.
- Decode ignores the dp bit; segmentos[7:1] is matched against the glyph table.
  - Glyph table (hex, 7 bits): 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, B=60, C=31, D=42, E=30, F=38.
  - Match: nibble written, valid=1, err=0.
  - No match: nibble retained, valid=0, err=1.
  - dp_o[k] = ~segmentos[0].
- update_o is registered. It pulses in the cycle after CAPTURE only if the written slot differs from its previous contents.
- Latency from a pattern change at the pins to the outputs: SYNC_STAGES + STABLE_CYCLES + 1 cycles (default 7).
- All anodes high, or two or more anodes low: no capture; existing digit slots hold their contents.
- Counter saturates at STABLE_CYCLES and does not wrap.
- Reset mid-TRACK: the partial count is discarded and the FSM restarts in IDLE.

Optional Feature:
- SEG7_CAPTURE_BLANK_EN: when defined, segmentos[7:1]=7F (all off) is a legal blank. It gives valid=0, err=0, and the nibble is retained.
- When not defined, 7F is treated as an invalid glyph (err=1).

Decomposition:
- Package seg7_pkg:
  - segment bit index constants (SEG_A..SEG_G, SEG_DP)
  - 16-entry glyph constant table
  - NUM_DIGITS=4
  - FSM state typedef/encoding (IDLE, TRACK, CAPTURE, HOLD)
- Sub-module seg7_glyph_decode: combinational, 7-bit pattern in; nibble, hit, and blank out.
- FSM, counter and digit registers stay in the top module.

Test Plan:
- Reset, then drive anodos=1110, segmentos=00000011 held 10 cycles -> after 7 cycles digits_o[3:0]=0, valid_o=0001, err_o=0, dp_o=0, one update_o pulse.
- Drive anodos=1101, segmentos=00010000 -> digits_o[7:4]=A, dp_o[1]=1, valid_o[1]=1, digit 0 unchanged.
- Hold a pattern for only 3 cycles (STABLE_CYCLES=4), then change it -> no capture, no update_o.
- Drive anodos=1110, segmentos=11111111 -> err_o[0]=1, valid_o[0]=0. With SEG7_CAPTURE_BLANK_EN: err_o[0]=0, valid_o[0]=0.
- Drive anodos=1100 (two low) for 20 cycles -> outputs unchanged, FSM in IDLE. Re-present the same captured pattern -> capture occurs with no update_o pulse.
- Assert rst_i during TRACK -> outputs 0 immediately (async). After release, a stable pattern is captured in the full 7 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block: segment bit positions,
// the hex glyph table (active-low, bit 6 = a ... bit 0 = g) and FSM encoding.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Bit positions inside the 8-bit segment bus
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Glyph for hex value i lives at index i; patterns are {a,b,c,d,e,f,g}, 0 = lit
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // True when exactly one anode is driven low
  function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] an);
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph matcher: 7-bit segment pattern in, hex nibble out.
// Optional SEG7_CAPTURE_BLANK_EN makes the all-off pattern (7F) a legal blank;
// without it blank_o is tied low and 7F decodes as an invalid glyph.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       hit_o,
  output logic       blank_o
);

  // Search the glyph table; table entries are unique so at most one hits
  always_comb begin
    nibble_o = '0;
    hit_o    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == GLYPH_TABLE[i]) begin
        nibble_o = 4'(i);
        hit_o    = 1'b1;
      end
    end
  end

`ifdef SEG7_CAPTURE_BLANK_EN
  assign blank_o = (pattern_i == 7'h7F);
`else
  assign blank_o = 1'b0;
`endif

endmodule

// File: rtl/seg7_capture.sv
// Recovers the hex digits shown on a 4-digit multiplexed 7-segment display.
// Pins are synchronised, a pattern must be stable STABLE_CYCLES samples before
// it is decoded into the slot selected by the low anode.
// Optional blank-glyph support via SEG7_CAPTURE_BLANK_EN (see seg7_glyph_decode).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  anodos_i,
  input  logic [7:0]  segmentos_i,
  output logic [15:0] digits_o,
  output logic [3:0]  valid_o,
  output logic [3:0]  dp_o,
  output logic [3:0]  err_o,
  output logic        update_o
);

  localparam logic [7:0] STABLE_CNT  = 8'(STABLE_CYCLES);
  // A single stable sample is already enough when STABLE_CYCLES is 1
  localparam state_e     ENTRY_STATE = (STABLE_CYCLES <= 1) ? CAPTURE : TRACK;

  logic [SYNC_STAGES-1:0][11:0] sync_q;
  logic [11:0]                  sample;
  logic                         sample_ok;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] track_q, track_d;   // pattern currently being qualified / held
  logic        capture_en;

  logic [NUM_DIGITS-1:0][3:0] digits_q;
  logic [NUM_DIGITS-1:0]      valid_q, dp_q, err_q;
  logic [NUM_DIGITS-1:0]      slot_changed;
  logic                       update_q;

  logic [6:0] dec_pattern;
  logic [3:0] dec_nib;
  logic       dec_hit, dec_blank;
  logic       val_new, err_new, dp_new;

  // Shift {anodes, segments} through the synchroniser chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], anodos_i, segmentos_i};
    end
  end

  assign sample    = sync_q[SYNC_STAGES-1];
  assign sample_ok = onehot_low(sample[11:8]);

  // FSM, stability counter and tracked pattern registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      track_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      track_q <= track_d;
    end
  end

  // Next-state logic: qualify a one-hot-low pattern, capture once, then hold
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    track_d    = track_q;
    capture_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_ok) begin
          track_d = sample;
          cnt_d   = 8'd1;
          state_d = ENTRY_STATE;
        end
      end
      TRACK: begin
        if (!sample_ok) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (sample != track_q) begin
          track_d = sample;
          cnt_d   = 8'd1;
          state_d = ENTRY_STATE;
        end else begin
          cnt_d = (cnt_q >= STABLE_CNT) ? STABLE_CNT : cnt_q + 8'd1;
          if (cnt_d == STABLE_CNT) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (sample == track_q) begin
          state_d = HOLD;
        end else if (sample_ok) begin
          track_d = sample;
          cnt_d   = 8'd1;
          state_d = ENTRY_STATE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dec_pattern = {track_q[SEG_A], track_q[SEG_B], track_q[SEG_C], track_q[SEG_D],
                        track_q[SEG_E], track_q[SEG_F], track_q[SEG_G]};

  seg7_glyph_decode u_decode (
    .pattern_i (dec_pattern),
    .nibble_o  (dec_nib),
    .hit_o     (dec_hit),
    .blank_o   (dec_blank)
  );

  assign val_new = dec_hit;
  assign err_new = ~dec_hit & ~dec_blank;
  assign dp_new  = ~track_q[SEG_DP];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic       sel;
      logic [3:0] nib_new;

      assign sel     = capture_en & ~track_q[8+gi];
      assign nib_new = dec_hit ? dec_nib : digits_q[gi];
      assign slot_changed[gi] = sel &
        ({nib_new, val_new, dp_new, err_new} != {digits_q[gi], valid_q[gi], dp_q[gi], err_q[gi]});

      // Slot register: written only when this anode's pattern is captured
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          digits_q[gi] <= '0;
          valid_q[gi]  <= 1'b0;
          dp_q[gi]     <= 1'b0;
          err_q[gi]    <= 1'b0;
        end else if (sel) begin
          digits_q[gi] <= nib_new;
          valid_q[gi]  <= val_new;
          dp_q[gi]     <= dp_new;
          err_q[gi]    <= err_new;
        end
      end
    end
  endgenerate

  // Pulse update alongside the slot write, only if the slot content changed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) update_q <= 1'b0;
    else       update_q <= |slot_changed;
  end

  assign digits_o = digits_q;
  assign valid_o  = valid_q;
  assign dp_o     = dp_q;
  assign err_o    = err_q;
  assign update_o = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: stimulus pushes expected snapshots,
// a monitor pops one on every update_o pulse and checks contents and latency.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  anodos_i;
  logic [7:0]  segmentos_i;
  logic [15:0] digits_o;
  logic [3:0]  valid_o, dp_o, err_o;
  logic        update_o;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  p;
    logic [3:0]  e;
    int          c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  localparam int LAT = 7;

  seg7_capture dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .anodos_i    (anodos_i),
    .segmentos_i (segmentos_i),
    .digits_o    (digits_o),
    .valid_o     (valid_o),
    .dp_o        (dp_o),
    .err_o       (err_o),
    .update_o    (update_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] v, input logic [3:0] p,
                      input logic [3:0] e);
    exp_t x;
    x.d = d; x.v = v; x.p = p; x.e = e; x.c = cyc;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
    anodos_i    = an;
    segmentos_i = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [15:0] d, input logic [3:0] v,
                           input logic [3:0] p, input logic [3:0] e);
    chk({name, "_digits"}, 32'(digits_o), 32'(d));
    chk({name, "_valid"},  32'(valid_o),  32'(v));
    chk({name, "_dp"},     32'(dp_o),     32'(p));
    chk({name, "_err"},    32'(err_o),    32'(e));
  endtask

  // Monitor: every update pulse must match the oldest expected snapshot
  always @(negedge clk) begin
    if (!rst_i && update_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_update", 32'(update_o), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("upd_digits",  32'(digits_o),  32'(x.d));
        chk("upd_valid",   32'(valid_o),   32'(x.v));
        chk("upd_dp",      32'(dp_o),      32'(x.p));
        chk("upd_err",     32'(err_o),     32'(x.e));
        chk("upd_latency", 32'(cyc - x.c), 32'(LAT));
        $display("update: digits=%04h valid=%b dp=%b err=%b", digits_o, valid_o, dp_o, err_o);
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    anodos_i    = 4'hF;
    segmentos_i = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    chk("reset_update", 32'(update_o), 32'd0);
    rst_i = 1'b0;

    // Digit 0 shows "0", dp off
    push(16'h0000, 4'b0001, 4'b0000, 4'b0000);
    drive(4'b1110, 8'h03, 10);

    // Digit 1 shows "A", dp lit
    push(16'h00A0, 4'b0011, 4'b0010, 4'b0000);
    drive(4'b1101, 8'h10, 10);

    // Only 3 stable cycles on digit 2: must not capture
    drive(4'b1011, 8'h9F, 3);
    drive(4'b1111, 8'hFF, 12);
    chk_state("short", 16'h00A0, 4'b0011, 4'b0010, 4'b0000);

    // Exactly STABLE_CYCLES stable cycles on digit 3 ("F"): captures
    push(16'hF0A0, 4'b1011, 4'b0010, 4'b0000);
    drive(4'b0111, 8'h71, 4);
    drive(4'b1111, 8'hFF, 12);

    // All-off pattern on digit 0
`ifdef SEG7_CAPTURE_BLANK_EN
    push(16'hF0A0, 4'b1010, 4'b0010, 4'b0000);
`else
    push(16'hF0A0, 4'b1010, 4'b0010, 4'b0001);
`endif
    drive(4'b1110, 8'hFF, 10);

    // Two anodes low: ignored
    drive(4'b1100, 8'h03, 20);
`ifdef SEG7_CAPTURE_BLANK_EN
    chk_state("twolow", 16'hF0A0, 4'b1010, 4'b0010, 4'b0000);
`else
    chk_state("twolow", 16'hF0A0, 4'b1010, 4'b0010, 4'b0001);
`endif

    // Same pattern re-presented: recaptured silently (no update expected)
    drive(4'b1110, 8'hFF, 12);
`ifdef SEG7_CAPTURE_BLANK_EN
    chk_state("represent", 16'hF0A0, 4'b1010, 4'b0010, 4'b0000);
`else
    chk_state("represent", 16'hF0A0, 4'b1010, 4'b0010, 4'b0001);
`endif
    chk("represent_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while tracking "5" on digit 1
    drive(4'b1101, 8'h49, 4);
    #2;
    rst_i = 1'b1;
    #1;
    chk_state("async_rst", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    push(16'h0050, 4'b0010, 4'b0000, 4'b0000);
    drive(4'b1101, 8'h49, 10);
    chk_state("after_rst", 16'h0050, 4'b0010, 4'b0000, 4'b0000);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
